adder_arbiter: RTL
==================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter ADD_LATENCY, default 4: cycles from operands driven on add_a/add_b/add_cin to matching result on add_sum/add_cout; legal range 1..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 en  input  1  grant enable; when low, no new request accepted, in-flight results still returned.
REQ-005 req0_valid / req1_valid  input  1 each  requester 0/1 has an operation pending.
REQ-006 req0_ready / req1_ready  output  1 each  requester 0/1 operation accepted this cycle.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  32 each  operands of requester 0/1.
REQ-008 req0_cin / req1_cin  input  1 each  carry-in of requester 0/1.
REQ-009 add_a, add_b  output  32 each  operands to shared pipelined adder.
REQ-010 add_cin  output  1  carry-in to shared adder.
REQ-011 add_sum  input  32, add_cout  input  1  shared adder result.
REQ-012 rsp_valid  output  1  result valid this cycle.
REQ-013 rsp_id  output  1  requester owning current result.
REQ-014 rsp_sum  output  32, rsp_cout  output  1  result forwarded to owner.
REQ-015 busy  output  1  at least one operation in flight.
REQ-016 grant_cnt0 / grant_cnt1  output  32 each  accepted-operation counters (see Configuration).

Function
REQ-017 Handshake: transfer on requester i occurs in a cycle where reqi_valid and reqi_ready are both 1; ready is combinational from valid, en, rr pointer; ready never asserted when valid is 0.
REQ-018 At most one of req0_ready/req1_ready is 1 in any cycle.
REQ-019 Arbitration: en=1, single valid requester -> it is granted; both valid -> requester other than last granted wins; en=0 -> none granted.
REQ-020 Round-robin pointer (last_grant) updates only on a transfer; unchanged in idle cycles.
REQ-021 Granted requester's a/b/cin drive add_a/add_b/add_cin in the transfer cycle; no transfer -> add_a=0, add_b=0, add_cin=0.
REQ-022 A tag shift register ADD_LATENCY deep carries {valid, id} per issued slot, advancing every cycle regardless of en.
REQ-023 Operation transferred in cycle t: rsp_valid=1, rsp_id=granted id, rsp_sum=add_sum, rsp_cout=add_cout in cycle t+ADD_LATENCY; rsp_sum/rsp_cout are pass-through of adder result gated to 0 when rsp_valid=0.
REQ-024 Throughput one operation per cycle; back-to-back grants yield back-to-back responses in grant order.
REQ-025 No response backpressure; requesters consume rsp when rsp_valid and rsp_id match.
REQ-026 busy = OR of all tag valid bits.
REQ-027 Arithmetic is 32-bit unsigned with carry-out; wrap-around is the adder's (0xFFFFFFFF+1, cin=0 -> sum 0, cout 1).

Reset
REQ-028 reset=1 clears every tag valid bit, sets last_grant=1 (requester 0 wins first tie), clears grant counters.
REQ-029 During reset cycle and cycle it is sampled, req0_ready=req1_ready=0, rsp_valid=0, busy=0; add_a/add_b/add_cin=0.
REQ-030 Reset mid-operation discards all in-flight operations; no rsp_valid for them after reset deasserts, including adder outputs still draining.

Configuration
REQ-031 Macro ADDER_ARB_STATS_EN defined: grant_cnt0/grant_cnt1 increment by 1 on each transfer of requester 0/1, saturating at 0xFFFFFFFF.
REQ-032 ADDER_ARB_STATS_EN undefined: ports remain, both driven constant 0, no counter registers synthesised; all other behaviour identical.

Verification
REQ-033 Only req0_valid=1, a=5, b=7, cin=1, en=1 -> req0_ready=1 same cycle; rsp_valid=1, rsp_id=0, rsp_sum=13, rsp_cout=0 exactly 4 cycles later.
REQ-034 Both valid continuously for 6 cycles after reset -> grants 0,1,0,1,0,1; responses 4 cycles later, same id order, sums correct.
REQ-035 req1: a=0xFFFFFFFF, b=1, cin=0 -> rsp_id=1, rsp_sum=0x00000000, rsp_cout=1.
REQ-036 en=0 with both valid for 3 cycles -> no ready, add_a=0; in-flight results still emerge; busy falls after last one.
REQ-037 Reset asserted 2 cycles after 2 grants -> no rsp_valid in following 8 cycles; next tie grants requester 0.
REQ-038 With ADDER_ARB_STATS_EN, 10 grants to req0 and 3 to req1 -> grant_cnt0=10, grant_cnt1=3; without it, both read 0.

Source files
------------

// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Two-requester round-robin front end for a shared, externally pipelined
//   32-bit adder. A request is accepted when it is valid and its ready is
//   high. The granted operands are sent to the adder in that same cycle.
//   A {valid, id} tag travels alongside the adder pipeline, so each result
//   leaves on rsp_* ADD_LATENCY cycles later and is marked with its owner.
//
// Parameters
//   ADD_LATENCY  adder pipeline depth in cycles (1..16), default 4
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   en                         grant enable (in-flight results still return)
//   req{0,1}_valid/_ready      request handshake per requester
//   req{0,1}_a/_b/_cin         operands per requester
//   add_a/add_b/add_cin        operands to shared adder (zero when idle)
//   add_sum/add_cout           shared adder result
//   rsp_valid/rsp_id           result valid and owning requester
//   rsp_sum/rsp_cout           result (zero when rsp_valid is low)
//   busy                       at least one operation in flight
//   grant_cnt0/grant_cnt1      saturating accepted-operation counters
//
// Build option
//   ADDER_ARB_STATS_EN  when defined, the grant counters are implemented.
//                       Otherwise both counter outputs read 0.
module adder_arbiter #(
  parameter int unsigned ADD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_cin,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_cin,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [31:0] add_sum,
  input  logic        add_cout,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_sum,
  output logic        rsp_cout,
  output logic        busy,
  output logic [31:0] grant_cnt0,
  output logic [31:0] grant_cnt1
);

  logic                   last_grant;
  logic [ADD_LATENCY-1:0] tag_valid;
  logic [ADD_LATENCY-1:0] tag_id;
  logic                   xfer;
  logic                   xfer_id;

  // When both requesters are valid, the one that was not granted last wins.
  // Reset blocks every grant, so nothing is accepted in the reset cycle.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (en && !reset) begin
      req0_ready = req0_valid && (!req1_valid || last_grant);
      req1_ready = req1_valid && (!req0_valid || !last_grant);
    end
  end

  assign xfer    = req0_ready || req1_ready;
  assign xfer_id = req1_ready;

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (req0_ready) begin
      add_a   = req0_a;
      add_b   = req0_b;
      add_cin = req0_cin;
    end else if (req1_ready) begin
      add_a   = req1_a;
      add_b   = req1_b;
      add_cin = req1_cin;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (xfer) begin
      last_grant <= xfer_id;
    end
  end

  // Tag slot 0 is loaded at the end of the transfer cycle. Slot k is
  // therefore visible k+1 cycles later, and the last slot lines up with the
  // adder output.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      for (int unsigned i = 1; i < ADD_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
      tag_valid[0] <= xfer;
      tag_id[0]    <= xfer_id;
    end
  end

  // The outputs are gated with reset so that the reset cycle itself is quiet.
  assign rsp_valid = tag_valid[ADD_LATENCY-1] && !reset;
  assign rsp_id    = rsp_valid && tag_id[ADD_LATENCY-1];
  assign rsp_sum   = rsp_valid ? add_sum : '0;
  assign rsp_cout  = rsp_valid && add_cout;
  assign busy      = (|tag_valid) && !reset;

`ifdef ADDER_ARB_STATS_EN
  logic [31:0] cnt0_q;
  logic [31:0] cnt1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (req0_ready && cnt0_q != '1) cnt0_q <= cnt0_q + 32'd1;
      if (req1_ready && cnt1_q != '1) cnt1_q <= cnt1_q + 32'd1;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule
